// File: rtl/wr_pack_16to128.sv
// Write-path width up-converter: packs IN_WIDTH beats into OUT_WIDTH words with keep/last marking.
// Define PACK_MSB_FIRST_EN to fill lanes starting from the most significant end.
module wr_pack_16to128 #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  parameter int RATIO     = OUT_WIDTH / IN_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RATIO-1:0]     out_keep,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

`ifdef PACK_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic [OUT_WIDTH-1:0] acc_reg;
  logic [OUT_WIDTH-1:0] merged_next;
  logic [RATIO-1:0]     keep_next;
  logic [LANE_W-1:0]    lane_reg;
  logic [OUT_WIDTH-1:0] data_reg;
  logic [RATIO-1:0]     keep_reg;
  logic                 last_reg;
  logic                 valid_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 accept;
  logic                 consume;
  logic                 close;

  assign in_ready = rst || !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_reg && out_ready;
  assign close    = accept && ((lane_reg == LAST_LANE) || in_last);

  // Lanes above the current one are still zero in acc_reg, so the merged word is already padded.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    localparam int POS = MSB_FIRST ? (RATIO - 1 - gi) : gi;
    assign merged_next[POS*IN_WIDTH +: IN_WIDTH] =
      (lane_reg == LANE_W'(gi)) ? in_data : acc_reg[POS*IN_WIDTH +: IN_WIDTH];
    assign keep_next[POS] = (LANE_W'(gi) <= lane_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      lane_reg  <= '0;
      data_reg  <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      if (consume) begin
        cnt_reg   <= cnt_reg + CNT_WIDTH'(1);
        valid_reg <= 1'b0;
      end
      if (accept) begin
        if (close) begin
          data_reg  <= merged_next;
          keep_reg  <= keep_next;
          last_reg  <= in_last;
          valid_reg <= 1'b1;
          acc_reg   <= '0;
          lane_reg  <= '0;
        end else begin
          acc_reg  <= merged_next;
          lane_reg <= lane_reg + LANE_W'(1);
        end
      end
    end
  end

  assign out_data  = data_reg;
  assign out_keep  = keep_reg;
  assign out_last  = last_reg;
  assign out_valid = valid_reg;
  assign word_cnt  = cnt_reg;

endmodule

// File: tb/tb_wr_pack_16to128.sv
// Randomized bench for wr_pack_16to128 against a beat-list reference model.
// Build with PACK_MSB_FIRST_EN to exercise the reversed lane order.
module tb_wr_pack_16to128;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   keep;
    logic         last;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_keep;
  logic         out_last;
  logic [15:0]  word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_beats[$];
  word_t       m_exp[$];
  word_t       got[$];
  bit          m_held;
  int          m_cnt;
  logic        obs_ready;
  logic        obs_valid;
  logic [127:0] obs_data;

  always #5 clk = ~clk;

  wr_pack_16to128 dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_keep(out_keep), .out_last(out_last), .word_cnt(word_cnt)
  );

  // Reference: a word is the list of accepted beats, closed by in_last or the eighth beat.
  task automatic model_beat(input logic [15:0] d, input logic l);
    word_t w;
    m_beats.push_back(d);
    if (l || m_beats.size() == 8) begin
      w.data = '0;
      w.keep = '0;
      for (int i = 0; i < m_beats.size(); i++) begin
`ifdef PACK_MSB_FIRST_EN
        w.data = w.data | (128'(m_beats[i]) << (16 * (7 - i)));
        w.keep[7-i] = 1'b1;
`else
        w.data = w.data | (128'(m_beats[i]) << (16 * i));
        w.keep[i] = 1'b1;
`endif
      end
      w.last = l;
      m_exp.push_back(w);
      m_held = 1'b1;
      m_beats.delete();
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, advance model, wait for next negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
    bit m_ready;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    if (out_valid && out_ready) got.push_back({out_data, out_keep, out_last});
    m_ready = !m_held || r;
    if (m_held && r) begin
      m_held = 1'b0;
      m_cnt++;
    end
    if (v && m_ready) model_beat(d, l);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_beats.delete();
    m_held = 1'b0;
    m_cnt = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || out_keep !== 8'h00 || out_last !== 1'b0)
      $display("FAIL reset_out got valid=%b keep=%h last=%b want 0/00/0", out_valid, out_keep, out_last);
    else n_pass++;
    n_checks++;
    if (out_data !== 128'h0 || word_cnt !== 16'h0)
      $display("FAIL reset_data got data=%h cnt=%0d want 0/0", out_data, word_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_beats.delete(); m_held = 1'b0; m_cnt = 0;
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    word_t want;
    got.delete(); m_exp.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    drain();
`ifdef PACK_MSB_FIRST_EN
    want = {128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'hFF, 1'b0};
`else
    want = {128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b0};
`endif
    n_checks++;
    if (got.size() != 1) $display("FAIL full_count got=%0d want=1", got.size());
    else begin
      n_pass++;
      $display("word data=%h keep=%h last=%b", got[0].data, got[0].keep, got[0].last);
      n_checks++;
      if (got[0] !== want) $display("FAIL full_word got=%h want=%h", got[0], want); else n_pass++;
      n_checks++;
      if (got[0] !== m_exp[0]) $display("FAIL full_model got=%h want=%h", got[0], m_exp[0]); else n_pass++;
    end
    n_checks++;
    if (word_cnt !== 16'd1) $display("FAIL full_cnt got=%0d want=1", word_cnt); else n_pass++;
  endtask

  task automatic test_partial();
    word_t want;
    logic [15:0] pat[3];
    pat[0] = 16'hAAAA; pat[1] = 16'hBBBB; pat[2] = 16'hCCCC;
    got.delete(); m_exp.delete();
    for (int i = 0; i < 3; i++) step(1'b1, pat[i], i == 2, 1'b1);
    // A following full word proves the lane pointer returned to 0.
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
    drain();
`ifdef PACK_MSB_FIRST_EN
    want = {128'hAAAA_BBBB_CCCC_0000_0000_0000_0000_0000, 8'hE0, 1'b1};
`else
    want = {128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA, 8'h07, 1'b1};
`endif
    n_checks++;
    if (got.size() != 2) $display("FAIL partial_count got=%0d want=2", got.size());
    else begin
      n_pass++;
      n_checks++;
      if (got[0] !== want) $display("FAIL partial_word got=%h want=%h", got[0], want); else n_pass++;
      n_checks++;
      if (got[1] !== m_exp[1]) $display("FAIL partial_next got=%h want=%h", got[1], m_exp[1]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]  beats[32];
    logic [127:0] held = '0;
    int idx = 0, stall = 0, guard = 0;
    bit first_seen = 0;
    do_reset();
    got.delete(); m_exp.delete();
    for (int i = 0; i < 32; i++) beats[i] = 16'($urandom);
    while ((idx < 32 || stall > 0) && guard < 200) begin
      if (!first_seen && out_valid) begin
        first_seen = 1;
        held = out_data;
        stall = 5;
      end
      step(idx < 32, beats[idx % 32], 1'b0, stall == 0);
      if (stall > 0) begin
        n_checks++;
        if (obs_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", obs_ready); else n_pass++;
        n_checks++;
        if (obs_data !== held) $display("FAIL stall_data got=%h want=%h", obs_data, held); else n_pass++;
        stall--;
      end
      if (idx < 32 && obs_ready) idx++;
      guard++;
    end
    n_checks++;
    if (guard >= 200) $display("FAIL b2b_timeout got=%0d want<200", guard); else n_pass++;
    drain();
    n_checks++;
    if (got.size() != 4 || m_exp.size() != 4)
      $display("FAIL b2b_count got=%0d want=4", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        $display("word %0d data=%h keep=%h", i, got[i].data, got[i].keep);
        n_checks++;
        if (got[i] !== m_exp[i]) $display("FAIL b2b_word%0d got=%h want=%h", i, got[i], m_exp[i]); else n_pass++;
      end
    end
    n_checks++;
    if (word_cnt !== 16'd4) $display("FAIL b2b_cnt got=%0d want=4", word_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    word_t want;
    do_reset();
    got.delete(); m_exp.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i * 16'h0101), 1'b0, 1'b1);
    drain();
`ifdef PACK_MSB_FIRST_EN
    want = {128'h0101_0202_0303_0404_0505_0606_0707_0808, 8'hFF, 1'b0};
`else
    want = {128'h0808_0707_0606_0505_0404_0303_0202_0101, 8'hFF, 1'b0};
`endif
    n_checks++;
    if (got.size() != 1) $display("FAIL midrst_count got=%0d want=1", got.size());
    else begin
      n_pass++;
      n_checks++;
      if (got[0] !== want) $display("FAIL midrst_word got=%h want=%h", got[0], want); else n_pass++;
    end
    n_checks++;
    if (word_cnt !== 16'd1) $display("FAIL midrst_cnt got=%0d want=1", word_cnt); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    got.delete(); m_exp.delete();
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    drain();
    n_checks++;
    if (got.size() != m_exp.size())
      $display("FAIL rand_count got=%0d want=%0d", got.size(), m_exp.size());
    else begin
      n_pass++;
      for (int i = 0; i < got.size(); i++) begin
        $display("word %0d data=%h keep=%h last=%b", i, got[i].data, got[i].keep, got[i].last);
        n_checks++;
        if (got[i] !== m_exp[i]) $display("FAIL rand_word%0d got=%h want=%h", i, got[i], m_exp[i]); else n_pass++;
      end
    end
    n_checks++;
    if (word_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt got=%0d want=%0d", word_cnt, 16'(m_cnt)); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    got.delete(); m_exp.delete();
    for (int i = 0; i < 65537; i++) step(1'b1, 16'($urandom), 1'b1, 1'b1);
    drain();
    n_checks++;
    if (got.size() != 65537) $display("FAIL wrap_count got=%0d want=65537", got.size()); else n_pass++;
    n_checks++;
    if (word_cnt !== 16'd1) $display("FAIL wrap_cnt got=%0d want=1", word_cnt); else n_pass++;
    if (got.size() > 0 && m_exp.size() > 0) begin
      n_checks++;
      if (got[got.size()-1] !== m_exp[m_exp.size()-1])
        $display("FAIL wrap_last got=%h want=%h", got[got.size()-1], m_exp[m_exp.size()-1]);
      else n_pass++;
    end
    $display("wrap words=%0d cnt=%0d", got.size(), word_cnt);
  endtask

`ifdef PACK_MSB_FIRST_EN
  task automatic test_msb();
    word_t want;
    do_reset();
    got.delete(); m_exp.delete();
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 16'h5678, 1'b1, 1'b1);
    drain();
    want = {128'h1234_5678_0000_0000_0000_0000_0000_0000, 8'hC0, 1'b1};
    n_checks++;
    if (got.size() != 1) $display("FAIL msb_count got=%0d want=1", got.size());
    else begin
      n_pass++;
      n_checks++;
      if (got[0] !== want) $display("FAIL msb_word got=%h want=%h", got[0], want); else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
`ifdef PACK_MSB_FIRST_EN
    test_msb();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wr_pack_16to128.md
# wr_pack_16to128

Width up-converter on the write path into the asymmetric FIFO: collects narrow 16-bit beats from the SD/LCD datapath and emits full 128-bit words to the FIFO write port. It is the write-side counterpart of the 128→16 read FIFO. Valid/ready handshake on both sides, with in-band end-of-burst marking and zero-padding of partial words. Single clock; sits directly in front of the FIFO `wr_data`/`wr_en`, with `out_ready` driven from `~wr_full`.

## Interface
Parameters:
- `IN_WIDTH`, 16: input beat width.
- `OUT_WIDTH`, 128: output word width; must be an integer multiple of `IN_WIDTH`.
- `RATIO`, `OUT_WIDTH/IN_WIDTH` (derived, 8): beats per word; legal range ≥2.
- `CNT_WIDTH`, 16: width of the emitted-word counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `IN_WIDTH`  input beat.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready` at a rising edge of `clk`.
- `in_last`  in  1  this beat ends the burst; the word closes after it.
- `out_data`  out  `OUT_WIDTH`  packed word.
- `out_valid`  out  1  word present.
- `out_ready`  in  1  word consumed when `out_valid && out_ready`.
- `out_keep`  out  `RATIO`  lane-valid mask; bit i set means lane i holds real data.
- `out_last`  out  1  word closed by `in_last`.
- `word_cnt`  out  `CNT_WIDTH`  count of words consumed since reset.

## Operation
State:
- Accumulator `acc` (`OUT_WIDTH`).
- Lane pointer `lane` (0..RATIO-1).
- Output register holding `out_data`, `out_keep`, `out_last`, `out_valid`.

Input acceptance:
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
- An accepted beat is written into lane `lane`. Default lane order is LSB-first: lane i occupies bits [i*IN_WIDTH +: IN_WIDTH]. The first beat of a word lands in bits [15:0].

Word closing:
- A beat closes the word when `lane == RATIO-1` or `in_last == 1`.
- Closing beat: the word (including the closing beat) transfers to the output register.
  - Lanes above the closing lane are forced to 0.
  - `out_keep` = ones in lanes 0..closing lane.
  - `out_last` = `in_last`.
  - `lane` ← 0 and `acc` ← 0.
- Non-closing beat: `lane` ← `lane`+1.

Output handshake:
- `out_valid` clears on consume unless a closing beat is accepted in the same cycle; in that case the new word loads and `out_valid` stays 1 (back-to-back words).
- `word_cnt` increments by 1 on each consume and wraps modulo 2^CNT_WIDTH.

Boundary conditions:
- `in_last` on lane 0: one-lane word, `out_keep` = 0x01, upper 112 bits = 0.
- `in_last` on lane 7: full word, `out_keep` = 0xFF, `out_last` = 1.
- `in_valid` low: no state change. Gaps between beats are allowed at any lane.
- Reset:
  - Reset values: `acc`=0, `lane`=0, `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `word_cnt`=0; `in_ready`=1 while in reset.
  - Asserting `rst` mid-word discards the partial word and any held output word. The first beat after reset lands in lane 0.

## Timing
- Latency: when the closing beat is accepted at edge N, `out_valid` is 1 from edge N to the next edge.
- Throughput: one beat per cycle sustained while `out_ready` = 1, i.e. one word per `RATIO` cycles.
- Stall: while `out_valid && !out_ready`:
  - `out_data`, `out_keep`, `out_last` are held stable.
  - `in_ready` = 0, and no accumulator or lane change occurs.
- All outputs except `in_ready` are registered.

## Configuration
- `PACK_MSB_FIRST_EN` defined:
  - Lane order is reversed. The first beat lands in bits [OUT_WIDTH-1 -: IN_WIDTH], and lane i occupies bits [(RATIO-1-i)*IN_WIDTH +: IN_WIDTH].
  - `out_keep` bit (RATIO-1-i) flags lane i.
  - Padding still zeroes the unfilled (low) bits.
- Not defined: LSB-first order as described in Operation.
- Handshake and timing are identical in both builds.

## Test plan
- 8 beats 0x0001..0x0008, `out_ready`=1 → one word 0x0008_0007_0006_0005_0004_0003_0002_0001, `out_keep`=0xFF, `out_last`=0, `word_cnt`=1.
- 3 beats 0xAAAA, 0xBBBB, 0xCCCC with `in_last` on the third → `out_data` = 0x...0000_CCCC_BBBB_AAAA (upper 80 bits 0), `out_keep`=0x07, `out_last`=1, `lane` returns to 0.
- 32 back-to-back beats, `out_ready` held 0 for 5 cycles after the first word → `in_ready`=0 during the stall, `out_data` stable, 4 words emitted in order, no beat lost or duplicated, `word_cnt`=4.
- `rst` pulsed after 5 beats of a word, then 8 beats 0x0101..0x0808 → no word emitted for the 5 discarded beats, next word = 0x0808_..._0101 with `out_keep`=0xFF.
- 65 537 single-lane `in_last` words → `word_cnt` wraps to 1.
- Build with `PACK_MSB_FIRST_EN`, 2 beats 0x1234, 0x5678 + `in_last` → `out_data` = 0x1234_5678_0000_..._0000, `out_keep`=0xC0.
